// File: rtl/grf_read_scoreboard.sv
// rtl/grf_read_scoreboard.sv - D-stage read hazard scoreboard: stall and forward-select for the two GRF read ports
//
// Tracks the register writes in flight in the E, M and W stages and, for each
// D-stage read port, picks the youngest in-flight producer of that register.
// The read stalls if that producer's result is not ready by the time the
// reader consumes it; otherwise the port is forwarded from the producer's stage.
//
// Ports:
//   Clock            rising-edge clock
//   Reset            synchronous, active-high; empties all tracking slots
//   D_Valid          D stage holds a real instruction
//   D_RA1 / D_RA2    D-stage read addresses
//   D_Tuse1/D_Tuse2  cycles after D until each read value is consumed
//   D_WA             D-stage destination register (0 = no write)
//   D_Tnew           cycles after entering E until the D instruction's result exists
//   Flush            kill the D instruction; E receives a bubble
//   Stall            hold PC/F/D and insert a bubble into E
//   Fwd1 / Fwd2      read source: 0=GRF, 1=E, 2=M, 3=W
//   E_Busy           E slot holds a write whose result is not yet available

module grf_read_scoreboard #(
    parameter int AW = 5,
    parameter int TW = 2
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          D_Valid,
    input  logic [AW-1:0] D_RA1,
    input  logic [AW-1:0] D_RA2,
    input  logic [TW-1:0] D_Tuse1,
    input  logic [TW-1:0] D_Tuse2,
    input  logic [AW-1:0] D_WA,
    input  logic [TW-1:0] D_Tnew,
    input  logic          Flush,
    output logic          Stall,
    output logic [1:0]    Fwd1,
    output logic [1:0]    Fwd2,
    output logic          E_Busy
);

    // Slot state. The W slot carries no counter: a write that reaches W is
    // always ready, because the GRF write-then-read happens in the same cycle.
    logic          e_valid_q, e_valid_d;
    logic [AW-1:0] e_wa_q,    e_wa_d;
    logic [TW-1:0] e_tnew_q,  e_tnew_d;
    logic          m_valid_q, m_valid_d;
    logic [AW-1:0] m_wa_q,    m_wa_d;
    logic [TW-1:0] m_tnew_q,  m_tnew_d;
    logic          w_valid_q, w_valid_d;
    logic [AW-1:0] w_wa_q,    w_wa_d;

    logic [1:0]    code1, code2;
    logic [TW-1:0] rem1, rem2;
    logic          alloc;

    // Youngest-first search: a younger match shadows older ones even when the
    // younger one is not ready yet. Returns {stage code, remaining tnew}.
    function automatic logic [TW+1:0] lookup(input logic [AW-1:0] ra);
        logic [1:0]    code;
        logic [TW-1:0] rem;
        code = 2'd0;
        rem  = '0;
        if (ra != '0) begin
            if (e_valid_q && (e_wa_q == ra)) begin
                code = 2'd1;
                rem  = e_tnew_q;
            end else if (m_valid_q && (m_wa_q == ra)) begin
                code = 2'd2;
                rem  = m_tnew_q;
            end else if (w_valid_q && (w_wa_q == ra)) begin
                code = 2'd3;
            end
        end
        return {code, rem};
    endfunction

    always_comb begin
        {code1, rem1} = lookup(D_RA1);
        {code2, rem2} = lookup(D_RA2);
        Fwd1   = code1;
        Fwd2   = code2;
        // rem is zero whenever a port has no match, so unmatched ports never stall.
        Stall  = D_Valid && ((rem1 > D_Tuse1) || (rem2 > D_Tuse2));
        E_Busy = e_valid_q && (e_tnew_q != '0);
    end

    always_comb begin
        // Flush kills the D instruction even while stalling.
        alloc     = D_Valid && !Stall && !Flush && (D_WA != '0);
        e_valid_d = alloc;
        e_wa_d    = alloc ? D_WA   : '0;
        e_tnew_d  = alloc ? D_Tnew : '0;
        // A bubble in E has all-zero fields, so copying it forward stays a bubble.
        m_valid_d = e_valid_q;
        m_wa_d    = e_wa_q;
        m_tnew_d  = (e_tnew_q == '0) ? '0 : e_tnew_q - 1'b1;
        w_valid_d = m_valid_q;
        w_wa_d    = m_wa_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            e_valid_q <= 1'b0;
            e_wa_q    <= '0;
            e_tnew_q  <= '0;
            m_valid_q <= 1'b0;
            m_wa_q    <= '0;
            m_tnew_q  <= '0;
            w_valid_q <= 1'b0;
            w_wa_q    <= '0;
        end else begin
            e_valid_q <= e_valid_d;
            e_wa_q    <= e_wa_d;
            e_tnew_q  <= e_tnew_d;
            m_valid_q <= m_valid_d;
            m_wa_q    <= m_wa_d;
            m_tnew_q  <= m_tnew_d;
            w_valid_q <= w_valid_d;
            w_wa_q    <= w_wa_d;
        end
    end

endmodule

// File: tb/tb_grf_read_scoreboard.sv
// tb/tb_grf_read_scoreboard.sv - self-checking bench for grf_read_scoreboard
module tb_grf_read_scoreboard;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       D_Valid;
    logic [4:0] D_RA1, D_RA2, D_WA;
    logic [1:0] D_Tuse1, D_Tuse2, D_Tnew;
    logic       Flush;
    logic       Stall;
    logic [1:0] Fwd1, Fwd2;
    logic       E_Busy;

    always #5 Clock = ~Clock;

    grf_read_scoreboard #(.AW(5), .TW(2)) dut (
        .Clock(Clock), .Reset(Reset), .D_Valid(D_Valid),
        .D_RA1(D_RA1), .D_RA2(D_RA2), .D_Tuse1(D_Tuse1), .D_Tuse2(D_Tuse2),
        .D_WA(D_WA), .D_Tnew(D_Tnew), .Flush(Flush),
        .Stall(Stall), .Fwd1(Fwd1), .Fwd2(Fwd2), .E_Busy(E_Busy)
    );

    typedef struct {
        bit       chk;
        bit       rst, v;
        bit [4:0] ra1, ra2;
        bit [1:0] tu1, tu2;
        bit [4:0] wa;
        bit [1:0] tn;
        bit       fl;
        bit       e_stall;
        bit [1:0] e_f1, e_f2;
        bit       e_busy;
    } vec_t;

    // One record per instruction issued into E, youngest first: [0]=E, [1]=M, [2]=W.
    typedef struct {
        bit       v;
        bit [4:0] wa;
        bit [1:0] tn;
    } rec_t;

    vec_t tbl[27];
    rec_t hist[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(bit chk, bit rst, bit v, bit [4:0] ra1, bit [4:0] ra2,
                                bit [1:0] tu1, bit [1:0] tu2, bit [4:0] wa, bit [1:0] tn,
                                bit fl, bit es, bit [1:0] ef1, bit [1:0] ef2, bit eb);
        vec_t r;
        r.chk = chk; r.rst = rst; r.v = v; r.ra1 = ra1; r.ra2 = ra2;
        r.tu1 = tu1; r.tu2 = tu2; r.wa = wa; r.tn = tn; r.fl = fl;
        r.e_stall = es; r.e_f1 = ef1; r.e_f2 = ef2; r.e_busy = eb;
        return r;
    endfunction

    // Remaining time of a producer issued `age` cycles ago; one in W is always ready.
    function automatic int remaining(input rec_t r, input int age);
        if (age >= 2) return 0;
        return (int'(r.tn) > age) ? int'(r.tn) - age : 0;
    endfunction

    function automatic void port_model(input bit [4:0] ra, output bit [1:0] code, output int rem);
        code = 2'd0;
        rem  = 0;
        if (ra != 5'd0) begin
            for (int a = 0; a < 3; a++) begin
                if (hist[a].v && hist[a].wa == ra) begin
                    code = 2'(a + 1);
                    rem  = remaining(hist[a], a);
                    break;
                end
            end
        end
    endfunction

    function automatic void model_out(output bit s, output bit [1:0] f1, output bit [1:0] f2, output bit b);
        int r1, r2;
        port_model(D_RA1, f1, r1);
        port_model(D_RA2, f2, r2);
        s = D_Valid && ((r1 > int'(D_Tuse1)) || (r2 > int'(D_Tuse2)));
        b = hist[0].v && (hist[0].tn != 2'd0);
    endfunction

    function automatic void clear_hist();
        rec_t bub;
        bub = '{v: 1'b0, wa: 5'd0, tn: 2'd0};
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(bub);
    endfunction

    // Advance the model across the coming clock edge using the current inputs.
    function automatic void model_step();
        bit s, b;
        bit [1:0] f1, f2;
        rec_t n;
        if (Reset) begin
            clear_hist();
        end else begin
            model_out(s, f1, f2, b);
            n.v  = D_Valid && !s && !Flush && (D_WA != 5'd0);
            n.wa = n.v ? D_WA : 5'd0;
            n.tn = n.v ? D_Tnew : 2'd0;
            hist.push_front(n);
            void'(hist.pop_back());
        end
    endfunction

    task automatic check(input bit es, input bit [1:0] ef1, input bit [1:0] ef2,
                         input bit eb, input string name);
        n_vec++;
        if (Stall !== es || Fwd1 !== ef1 || Fwd2 !== ef2 || E_Busy !== eb) begin
            n_bad++;
            $display("FAIL %s: got Stall=%0b Fwd1=%0d Fwd2=%0d E_Busy=%0b, want Stall=%0b Fwd1=%0d Fwd2=%0d E_Busy=%0b",
                     name, Stall, Fwd1, Fwd2, E_Busy, es, ef1, ef2, eb);
        end
    endtask

    task automatic drive(input vec_t t);
        Reset = t.rst; D_Valid = t.v; D_RA1 = t.ra1; D_RA2 = t.ra2;
        D_Tuse1 = t.tu1; D_Tuse2 = t.tu2; D_WA = t.wa; D_Tnew = t.tn; Flush = t.fl;
    endtask

    initial begin
        bit es, eb;
        bit [1:0] ef1, ef2;

        //          chk rst v  ra1 ra2 tu1 tu2 wa tn fl | st f1 f2 busy
        // reset with a writing instruction present, then slots must be empty
        tbl[0]  = mk(0, 1, 1,  0,  0,  0,  0,  5, 1, 0,   0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 1,  0,  0,  0,  0,  5, 1, 0,   0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 1,  5,  0,  0,  0,  0, 0, 0,   0, 0, 0, 0);
        // load-use: two stall cycles, then forward from W
        tbl[3]  = mk(1, 0, 1,  0,  0,  0,  0,  8, 2, 0,   0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 1,  8,  0,  0,  0,  0, 0, 0,   1, 1, 0, 1);
        tbl[5]  = mk(1, 0, 1,  8,  0,  0,  0,  0, 0, 0,   1, 2, 0, 0);
        tbl[6]  = mk(1, 0, 1,  8,  0,  0,  0,  0, 0, 0,   0, 3, 0, 0);
        // ALU chain: forward from E, then from M
        tbl[7]  = mk(1, 0, 1,  0,  0,  0,  0,  9, 1, 0,   0, 0, 0, 0);
        tbl[8]  = mk(1, 0, 1,  0,  9,  0,  1,  0, 0, 0,   0, 0, 1, 1);
        tbl[9]  = mk(1, 0, 1,  0,  9,  0,  1,  0, 0, 0,   0, 0, 2, 0);
        // shadowing: unready E hides ready M
        tbl[10] = mk(1, 0, 1,  0,  0,  0,  0,  4, 1, 0,   0, 0, 0, 0);
        tbl[11] = mk(1, 0, 1,  0,  0,  0,  0,  4, 2, 0,   0, 0, 0, 1);
        tbl[12] = mk(1, 0, 1,  4,  0,  0,  0,  0, 0, 0,   1, 1, 0, 1);
        // $0 is never tracked
        tbl[13] = mk(1, 0, 1,  0,  0,  0,  0,  0, 3, 0,   0, 0, 0, 0);
        tbl[14] = mk(1, 0, 1,  0,  0,  0,  0,  0, 0, 0,   0, 0, 0, 0);
        // flush during stall; the older write still forwards from W
        tbl[15] = mk(1, 0, 1,  0,  0,  0,  0,  3, 2, 0,   0, 0, 0, 0);
        tbl[16] = mk(1, 0, 1,  3,  0,  0,  0,  7, 1, 1,   1, 1, 0, 1);
        tbl[17] = mk(1, 0, 1,  3,  0,  0,  0,  0, 0, 0,   1, 2, 0, 0);
        tbl[18] = mk(1, 0, 1,  3,  0,  0,  0,  0, 0, 0,   0, 3, 0, 0);
        // flushed writer must not allocate
        tbl[19] = mk(1, 0, 1,  0,  0,  0,  0,  7, 1, 1,   0, 0, 0, 0);
        tbl[20] = mk(1, 0, 1,  7,  0,  0,  0,  0, 0, 0,   0, 0, 0, 0);
        // invalid D neither allocates nor stalls
        tbl[21] = mk(1, 0, 0,  0,  0,  0,  0,  6, 2, 0,   0, 0, 0, 0);
        tbl[22] = mk(1, 0, 1,  6,  0,  0,  0,  0, 0, 0,   0, 0, 0, 0);
        tbl[23] = mk(1, 0, 1,  0,  0,  0,  0,  6, 3, 0,   0, 0, 0, 0);
        tbl[24] = mk(1, 0, 0,  6,  0,  0,  0,  0, 0, 0,   0, 1, 0, 1);
        // reset mid-stall: tracking lost afterwards
        tbl[25] = mk(1, 1, 1,  6,  0,  0,  0,  0, 0, 0,   1, 2, 0, 0);
        tbl[26] = mk(1, 0, 1,  6,  0,  0,  0,  0, 0, 0,   0, 0, 0, 0);

        clear_hist();
        drive(tbl[0]);

        for (int i = 0; i < 27; i++) begin
            @(negedge Clock);
            drive(tbl[i]);
            #1;
            if (tbl[i].chk) check(tbl[i].e_stall, tbl[i].e_f1, tbl[i].e_f2, tbl[i].e_busy, $sformatf("table[%0d]", i));
            model_step();
        end

        for (int i = 0; i < 400; i++) begin
            @(negedge Clock);
            Reset   = ($urandom_range(0, 49) == 0);
            D_Valid = ($urandom_range(0, 9) != 0);
            D_RA1   = 5'($urandom_range(0, 3));
            D_RA2   = 5'($urandom_range(0, 3));
            D_Tuse1 = 2'($urandom_range(0, 3));
            D_Tuse2 = 2'($urandom_range(0, 3));
            D_WA    = 5'($urandom_range(0, 3));
            D_Tnew  = 2'($urandom_range(0, 3));
            Flush   = ($urandom_range(0, 9) == 0);
            #1;
            model_out(es, ef1, ef2, eb);
            check(es, ef1, ef2, eb, $sformatf("random[%0d]", i));
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
